// File: rtl/l4_flatten_reader.sv
// Streams the pooled layer-4 feature maps from the L4 BRAM as one flattened vector.
// Credit control keeps the skid FIFO from overflowing, so FC backpressure never loses a word.
module l4_flatten_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int MAP_SIZE   = 25,
    parameter int NUM_CH     = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_position,
    output logic                  l4_rd_en,
    output logic [ADDR_WIDTH-1:0] l4_rd_addr,
    input  logic [DATA_WIDTH-1:0] l4_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL = NUM_CH * MAP_SIZE;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] popcount(input logic [RD_LATENCY-1:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    state_t                  state_r, state_next_s;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [IDX_W-1:0]        rd_idx_r;
    logic                    rd_en_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic                    rd_last_r;
    logic [RD_LATENCY-1:0]   vld_pipe_r;
    logic [RD_LATENCY-1:0]   last_pipe_r;
    logic [DATA_WIDTH-1:0]   fifo_data_r [FIFO_DEPTH];
    logic                    fifo_last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                    pop_s, push_s, issue_s, idx_last_s, head_last_s;
    logic [7:0]              occ_s;

    assign pop_s       = (count_r != CNT_W'(0)) && out_ready;
    assign push_s      = vld_pipe_r[RD_LATENCY-1];
    assign idx_last_s  = (rd_idx_r == IDX_W'(TOTAL - 1));
    assign head_last_s = fifo_last_r[rd_ptr_r];
    // Occupancy counts every issued read not yet consumed; a pop this cycle frees its slot now.
    assign occ_s       = 8'(rd_en_r) + popcount(vld_pipe_r) + 8'(count_r) - 8'(pop_s);
    assign issue_s     = (state_r == ST_RUN) && ((occ_s + 8'd1) <= 8'(FIFO_DEPTH));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (issue_s && idx_last_s) state_next_s = ST_DRAIN;
                else                       state_next_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) state_next_s = ST_DONE;
                else                      state_next_s = ST_DRAIN;
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Base latch and read index counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r   <= '0;
            rd_idx_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            base_r   <= base_position;
            rd_idx_r <= '0;
        end else if (issue_s) begin
            rd_idx_r <= rd_idx_r + IDX_W'(1);
        end
    end

    // Registered BRAM read port; the sum wraps modulo the address space
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
            rd_last_r <= 1'b0;
        end else begin
            rd_en_r   <= issue_s;
            rd_last_r <= issue_s && idx_last_s;
            if (issue_s) rd_addr_r <= base_r + ADDR_WIDTH'(rd_idx_r);
        end
    end

    // Valid/last tags travelling alongside the BRAM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_r  <= '0;
            last_pipe_r <= '0;
        end else begin
            vld_pipe_r[0]  <= rd_en_r;
            last_pipe_r[0] <= rd_last_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
        end
    end

    // Skid FIFO storage, pointers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= '0;
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= l4_dout;
                fifo_last_r[wr_ptr_r] <= last_pipe_r[RD_LATENCY-1];
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    assign l4_rd_en   = rd_en_r;
    assign l4_rd_addr = rd_addr_r;
    assign out_valid  = (count_r != CNT_W'(0));
    assign out_data   = out_valid ? fifo_data_r[rd_ptr_r] : '0;
    assign out_last   = out_valid ? fifo_last_r[rd_ptr_r] : 1'b0;
    assign busy       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_l4_flatten_reader.sv
// Scoreboard bench for l4_flatten_reader: a BRAM model with two-cycle latency,
// directed transfers, and a monitor that checks words, addresses, stalls and done.
module tb_l4_flatten_reader;

    localparam int TOTAL = 400;
    localparam int DEPTH = 4;

    logic        clk, rst, start;
    logic [11:0] base_position;
    logic        l4_rd_en;
    logic [11:0] l4_rd_addr;
    logic [15:0] l4_dout;
    logic [15:0] out_data;
    logic        out_valid, out_ready, out_last, busy, done;

    l4_flatten_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_position(base_position),
        .l4_rd_en(l4_rd_en), .l4_rd_addr(l4_rd_addr), .l4_dout(l4_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q [$];
    logic [11:0] cur_base;
    int rd_cnt, acc_cnt, done_cnt;
    int ready_mode;
    logic [15:0] mem [0:4095];
    logic [15:0] stage1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: address registered, then output registered
    always @(posedge clk) begin
        if (l4_rd_en) stage1 <= mem[l4_rd_addr];
        l4_dout <= stage1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // out_ready driver: 0 always ready, 1 random, 2 toggling, 3 stalled
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = ~out_ready;
                3: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: addresses, credit bound, scoreboard pops, stall stability, done pulse
    initial begin
        logic        stalled_prev;
        logic [15:0] prev_data;
        logic        prev_last;
        logic [16:0] e;
        stalled_prev = 1'b0;
        prev_data = 16'h0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                if (l4_rd_en) begin
                    chk("rd_addr", 32'(l4_rd_addr), 32'(12'(cur_base + 12'(rd_cnt))));
                    rd_cnt++;
                    chk("credit", 32'((rd_cnt - acc_cnt) <= DEPTH), 32'd1);
                end
                if (stalled_prev) begin
                    chk("stall_hold", 32'({out_valid, out_last, out_data}),
                        32'({1'b1, prev_last, prev_data}));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'({out_last, out_data}), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", 32'({out_last, out_data}), 32'(e));
                    end
                    acc_cnt++;
                end
                stalled_prev = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
                if (done) begin
                    done_cnt++;
                    chk("done_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic load_mem(input logic [11:0] b);
        for (int a = 0; a < 4096; a++) mem[a] = 16'hC000 ^ 16'(a);
        for (int i = 0; i < TOTAL; i++) mem[12'(b + 12'(i))] = 16'h0100 + 16'(i);
    endtask

    task automatic start_pulse(input logic [11:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_position = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic begin_transfer(input logic [11:0] b);
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) begin
            exp_q.push_back({(i == TOTAL - 1) ? 1'b1 : 1'b0, 16'h0100 + 16'(i)});
        end
        cur_base = b;
        rd_cnt = 0;
        acc_cnt = 0;
        start_pulse(b);
    endtask

    task automatic wait_acc(input int n);
        int k;
        for (k = 0; k < 3000 && acc_cnt < n; k++) @(negedge clk);
        if (acc_cnt < n) chk("wait_acc_timeout", 32'(acc_cnt), 32'(n));
    endtask

    task automatic finish_transfer(input int d0, input string tag);
        int k;
        for (k = 0; k < 3000 && done_cnt <= d0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_reads"}, 32'(rd_cnt), 32'(TOTAL));
        chk({tag, "_idle"}, 32'({busy, out_valid, l4_rd_en}), 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        start = 1'b0;
        base_position = 12'h000;
        ready_mode = 0;
        cur_base = 12'h000;
        rd_cnt = 0;
        acc_cnt = 0;
        done_cnt = 0;
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", 32'({l4_rd_en, out_valid, out_last, busy, done}), 32'd0);
        chk("reset_data", 32'({l4_rd_addr, out_data}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Order check with out_ready held high
        load_mem(12'h040);
        ready_mode = 0;
        d0 = done_cnt;
        begin_transfer(12'h040);
        finish_transfer(d0, "order");

        // Random 50% backpressure
        ready_mode = 1;
        d0 = done_cnt;
        begin_transfer(12'h040);
        finish_transfer(d0, "random");

        // Full stall: only FIFO_DEPTH reads may be outstanding
        ready_mode = 3;
        d0 = done_cnt;
        begin_transfer(12'h040);
        repeat (50) @(posedge clk);
        chk("stall_reads", 32'(rd_cnt), 32'(DEPTH));
        chk("stall_no_accept", 32'(acc_cnt), 32'd0);
        ready_mode = 0;
        finish_transfer(d0, "stall");

        // Address wrap with a toggling out_ready
        load_mem(12'hFF0);
        ready_mode = 2;
        d0 = done_cnt;
        begin_transfer(12'hFF0);
        finish_transfer(d0, "wrap");

        // Reset mid-transfer, then a fresh transfer from index 0
        load_mem(12'h040);
        ready_mode = 0;
        d0 = done_cnt;
        begin_transfer(12'h040);
        wait_acc(137);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", 32'({l4_rd_en, out_valid, out_last, busy, done}), 32'd0);
        chk("midrst_data", 32'({l4_rd_addr, out_data}), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        begin_transfer(12'h040);
        finish_transfer(d0, "after_rst");

        // Start while busy is ignored
        d0 = done_cnt;
        begin_transfer(12'h040);
        wait_acc(10);
        start_pulse(12'h300);
        finish_transfer(d0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
